// File: rtl/bit_population_generator_if.sv
// Request/result bundle for bit_population_generator: a requested population
// count goes in, a word with exactly that many set bits comes out.
interface bit_population_generator_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count_i;
  logic             count_val_i;
  logic             count_rdy_o;
  logic [WIDTH-1:0] data_o;
  logic             data_val_o;

  modport master (
    output count_i,
    output count_val_i,
    input  count_rdy_o,
    input  data_o,
    input  data_val_o
  );

  modport slave (
    input  count_i,
    input  count_val_i,
    output count_rdy_o,
    output data_o,
    output data_val_o
  );
endinterface

// File: rtl/bit_population_generator.sv
// Builds a WIDTH-bit word with a requested number of set bits, placing one bit
// per cycle at an LFSR-chosen position (first free bit at or after the candidate).
module bit_population_generator #(
  parameter int          WIDTH = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  bit_population_generator_if.slave     bus
);
  localparam int          IW        = $clog2(WIDTH);
  localparam int          CW        = IW + 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CW-1:0] W_CW    = CW'(WIDTH);
  localparam logic [IW:0]   W_IW1   = (IW + 1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [15:0]      r_lfsr;
  logic [CW-1:0]    r_rem;
  logic             r_data_val;

  logic [15:0]      w_lfsr_next;
  logic [IW:0]      w_cand_raw;
  logic [IW-1:0]    w_cand;
  logic [WIDTH-1:0] w_free_rot;
  logic [IW-1:0]    w_offset;
  logic [IW:0]      w_probe_sum;
  logic [IW-1:0]    w_probe;
  logic [CW-1:0]    w_count_clamped;

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  // Fold the raw LFSR slice into range; only non-power-of-2 widths can overflow.
  assign w_cand_raw = {1'b0, r_lfsr[IW-1:0]};
  assign w_cand     = (w_cand_raw >= W_IW1) ? IW'(w_cand_raw - W_IW1) : w_cand_raw[IW-1:0];

  // w_free_rot[j] is the free flag of position (cand + j) mod WIDTH.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    logic [IW:0]   w_idx_sum;
    logic [IW-1:0] w_idx;
    assign w_idx_sum     = {1'b0, w_cand} + (IW + 1)'(gi);
    assign w_idx         = (w_idx_sum >= W_IW1) ? IW'(w_idx_sum - W_IW1) : w_idx_sum[IW-1:0];
    assign w_free_rot[gi] = ~r_word[w_idx];
  end

  always_comb begin
    w_offset = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (w_free_rot[j]) begin
        w_offset = IW'(j);
      end
    end
  end

  assign w_probe_sum = {1'b0, w_cand} + {1'b0, w_offset};
  assign w_probe     = (w_probe_sum >= W_IW1) ? IW'(w_probe_sum - W_IW1) : w_probe_sum[IW-1:0];

  assign w_count_clamped = (bus.count_i > W_CW) ? W_CW : bus.count_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_lfsr     <= SEED_EFF;
      r_rem      <= '0;
      r_data_val <= 1'b0;
    end else begin
      r_data_val <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.count_val_i) begin
            r_word <= '0;
            r_rem  <= w_count_clamped;
            if (w_count_clamped == '0) begin
              r_state    <= DONE;
              r_data_val <= 1'b1;
            end else begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          r_word[w_probe] <= 1'b1;
          r_rem           <= r_rem - CW'(1);
          r_lfsr          <= w_lfsr_next;
          if (r_rem == CW'(1)) begin
            r_state    <= DONE;
            r_data_val <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.count_rdy_o = (r_state == IDLE);
  assign bus.data_o      = r_word;
  assign bus.data_val_o  = r_data_val;

endmodule

// File: tb/tb_bit_population_generator.sv
// Bench for bit_population_generator: fixed vectors, hand-built corner
// sequences and random requests scored against a placement model.
module tb_bit_population_generator;
  localparam int          WIDTH = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   m_lfsr;

  bit_population_generator_if #(.WIDTH(WIDTH)) bus ();

  bit_population_generator #(.WIDTH(WIDTH), .SEED(SEED)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Placement model: candidate = lfsr mod 16, walk upward to the first free bit.
  task automatic model_gen(input int cnt, output logic [15:0] w);
    int n;
    int c;
    n = (cnt > WIDTH) ? WIDTH : cnt;
    w = '0;
    for (int b = 0; b < n; b++) begin
      c = m_lfsr % WIDTH;
      while (w[c]) c = (c + 1) % WIDTH;
      w[c] = 1'b1;
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
    end
  endtask

  // Called at a negedge. Issues one request and checks latency, strobe width,
  // ready profile and the resulting word.
  task automatic do_req(input int cnt, input logic [15:0] exp, input string tag);
    int n;
    int wait_cyc;
    n = (cnt > WIDTH) ? WIDTH : cnt;
    bus.count_i     = 5'(cnt);
    bus.count_val_i = 1'b1;
    wait_cyc = 0;
    while (!bus.count_rdy_o && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk({tag, " rdy_before"}, 32'(bus.count_rdy_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.count_val_i = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk({tag, " rdy_busy"}, 32'(bus.count_rdy_o), 32'd0);
      if (k <= n) begin
        chk({tag, " no_early_strobe"}, 32'(bus.data_val_o), 32'd0);
      end else begin
        chk({tag, " strobe"}, 32'(bus.data_val_o), 32'd1);
        chk({tag, " word"}, 32'(bus.data_o), 32'(exp));
        chk({tag, " popcount"}, 32'($countones(bus.data_o)), 32'(n));
      end
    end
    @(negedge clk);
    chk({tag, " strobe_one_cycle"}, 32'(bus.data_val_o), 32'd0);
    chk({tag, " rdy_after"}, 32'(bus.count_rdy_o), 32'd1);
    chk({tag, " word_held"}, 32'(bus.data_o), 32'(exp));
    $display("req %s count=%0d word=%h", tag, cnt, bus.data_o);
  endtask

  typedef struct {
    int          cnt;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] mw;
  int          rcnt;
  int          gap;

  initial begin
    vecs[0].cnt = 0;  vecs[0].exp = 16'h0000;
    vecs[1].cnt = 2;  vecs[1].exp = 16'h0003;
    vecs[2].cnt = 16; vecs[2].exp = 16'hFFFF;
    vecs[3].cnt = 20; vecs[3].exp = 16'hFFFF;

    bus.count_i     = '0;
    bus.count_val_i = 1'b0;
    m_lfsr          = 32'(SEED);

    // Reset state, including ready while reset is held.
    repeat (2) @(negedge clk);
    chk("reset rdy", 32'(bus.count_rdy_o), 32'd1);
    chk("reset data", 32'(bus.data_o), 32'd0);
    chk("reset val", 32'(bus.data_val_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      model_gen(vecs[i].cnt, mw);
      do_req(vecs[i].cnt, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Valid held high with count 3: an acceptance every 5 cycles.
    bus.count_i     = 5'd3;
    bus.count_val_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("hold rdy", 32'(bus.count_rdy_o), ((i % 5) == 0) ? 32'd1 : 32'd0);
      if ((i % 5) == 0) model_gen(3, mw);
      if ((i % 5) == 4) begin
        chk("hold strobe", 32'(bus.data_val_o), 32'd1);
        chk("hold word", 32'(bus.data_o), 32'(mw));
        chk("hold popcount", 32'($countones(bus.data_o)), 32'd3);
        $display("req hold count=3 word=%h", bus.data_o);
      end else begin
        chk("hold no_strobe", 32'(bus.data_val_o), 32'd0);
      end
      @(negedge clk);
    end
    bus.count_val_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of an 8-bit fill.
    bus.count_i     = 5'd8;
    bus.count_val_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.count_val_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset data", 32'(bus.data_o), 32'd0);
    chk("midreset val", 32'(bus.data_val_o), 32'd0);
    chk("midreset rdy", 32'(bus.count_rdy_o), 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lfsr = 32'(SEED);
    for (int i = 0; i < 12; i++) begin
      chk("postreset no_strobe", 32'(bus.data_val_o), 32'd0);
      @(negedge clk);
    end
    model_gen(1, mw);
    do_req(1, 16'h0002, "after_reset");

    // Random requests scored against the model.
    for (int r = 0; r < 1500; r++) begin
      rcnt = int'($urandom_range(0, 31));
      model_gen(rcnt, mw);
      do_req(rcnt, mw, $sformatf("rnd%0d", r));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
